softmax_arbiter: RTL and testbench
==================================

# softmax_arbiter

Round-robin scheduler that shares one N-lane `softmax` pipeline among R requesters, such as attention heads. It sits between the requesters and the `softmax` instance. It registers each granted vector into the pipeline and records the requester ID in an in-order tag FIFO. It pairs each pipeline result with the ID at the FIFO head and stalls the whole pipeline through `sm_en` while the consumer withholds `rsp_ready`.

## Interface
- `N`, 8, softmax lane count; must match the `softmax` instance.
- `R`, 4, number of requesters, at least 2.
- `DEPTH`, 8, maximum vectors in flight; tag FIFO depth; power of 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset. The same net also resets the `softmax` instance.
- `req_valid` input R: bit r = requester r holds a vector.
- `req_data_flat` input R*N*16: requester r's vector at `[r*N*16 +: N*16]`, Q6.10 per lane.
- `req_ready` output R: one-hot or zero grant; transfer occurs when `req_valid[r] & req_ready[r]`.
- `sm_valid_in` output 1: drives `softmax.valid_in`.
- `sm_in_x_flat` output N*16: drives `softmax.in_x_flat`.
- `sm_en` output 1: drives `softmax.en`.
- `sm_valid_out` input 1: from `softmax.valid_out`.
- `sm_prob_flat` input N*16: from `softmax.prob_flat`.
- `rsp_valid` output 1: result available.
- `rsp_id` output clog2(R): requester that owns the result.
- `rsp_data_flat` output N*16: result probabilities; equal to `sm_prob_flat`.
- `rsp_ready` input 1: consumer accepts the result.
- `inflight` output clog2(DEPTH+1): vectors issued but not yet retired.
- `err_orphan` output 1: sticky; `sm_valid_out` arrived while the tag FIFO was empty.

## Operation
- **Reset values** (when `rst`=0 at an edge): `req_ready`=0, `sm_valid_in`=0, `sm_in_x_flat`=0, `inflight`=0, `err_orphan`=0, RR pointer=0, FIFO empty.
- **Arbitration:** `can_issue` = `sm_en` & (`inflight` < DEPTH). When `can_issue` holds, `req_ready` grants the first set `req_valid` bit, searching from the RR pointer upward modulo R. Otherwise `req_ready`=0.
- **RR pointer:** after a grant to r, the pointer becomes (r+1) mod R. The pointer holds when there is no grant.
- **Issue:** on a transfer, `sm_in_x_flat` <= the granted requester's slice, `sm_valid_in` <= 1, and r is pushed into the tag FIFO.
- **No transfer, `sm_en`=1:** `sm_valid_in` <= 0.
- **`sm_en`=0:** `sm_valid_in` and `sm_in_x_flat` hold their values, because the stalled pipeline does not sample them.
- **Response:** `rsp_valid` = `sm_valid_out` & FIFO not empty. `rsp_id` = FIFO head. `rsp_data_flat` = `sm_prob_flat`.
- **Retire:** occurs when `rsp_valid` & `rsp_ready`; pops the FIFO.
- **Stall:** `sm_en` = !(`sm_valid_out` & !`rsp_ready`). This is combinational; the frozen pipeline keeps presenting the same result.
- **Inflight counter:** +1 on issue, -1 on retire, unchanged when both happen in the same cycle. FIFO push and pop in the same cycle are legal, including when the FIFO is full, because retire frees the slot that cycle.
- **Orphan:** `sm_valid_out` with the FIFO empty sets `err_orphan`. The result is dropped, `rsp_valid` stays 0, and nothing is popped. `err_orphan` clears only on reset.
- **Reset mid-operation:** the FIFO and counters flush and the `softmax` pipeline is cleared by the shared `rst`. No stale results are emitted after reset.

## Timing
- Grant is combinational within the cycle. `sm_valid_in` rises on the edge that accepts the transfer, so there is 1 cycle from grant to the pipeline input.
- End-to-end latency = 1 + `softmax` pipeline latency while `rsp_ready`=1. Each cycle of `rsp_ready`=0 with `rsp_valid`=1 adds one cycle to every in-flight vector.
- Throughput is one vector per cycle until `inflight` reaches DEPTH. In that state a grant in the same cycle still occurs if a retire happens that cycle, because the count is compared before update and retire is folded in: `can_issue` uses (`inflight` - retire) < DEPTH.
- With all R requesters continuously valid, grants rotate 0,1,…,R-1,0 with no requester skipped.

## Structure
- **Shared package `softmax_pkg`:** `LANE_W`=16, `Q_FRAC`=10, function `clog2`, and the ID typedef width for R.
- **Sub-module `tag_fifo`** (DEPTH × clog2(R)):
  - push, pop, head, empty, full.
  - Read and write pointers one bit wider than the address.
  - Same-cycle push and pop supported.
- The round-robin priority encoder stays inline.

## Test plan
- Single requester 2 sends a vector with lanes x=0x0400, y=0, rsp_ready=1 → one rsp with rsp_id=2 and data equal to a direct `softmax` run; inflight returns to 0.
- All 4 requesters held valid for 12 cycles → grant order 0,1,2,3 repeated 3 times; rsp_id sequence identical to the grant order.
- rsp_ready=0 for 5 cycles mid-stream → sm_en=0 for exactly those cycles; no response lost or duplicated; ids in order.
- DEPTH=8 with rsp_ready=0 → exactly 8 issues, then req_ready=0; one retire permits exactly one new grant in the same cycle.
- Force sm_valid_out=1 with the FIFO empty → err_orphan=1 sticky and rsp_valid=0; rst=0 for 1 cycle → all outputs return to their reset values.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath and its request arbiter:
// lane format, a constant-safe clog2 and the requester ID type.
package softmax_pkg;

    localparam int LANE_W = 16;
    localparam int Q_FRAC = 10;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    localparam int R_DEFAULT = 4;
    localparam int ID_W      = clog2(R_DEFAULT);

    typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester IDs for vectors in flight through softmax.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tag_fifo
    import softmax_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/softmax_arbiter.sv
// Round-robin front end sharing one softmax pipeline among R requesters;
// results are tagged with the owning requester via an in-order tag FIFO.
module softmax_arbiter
    import softmax_pkg::*;
#(
    parameter int N     = 8,
    parameter int R     = 4,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [R-1:0]              req_valid,
    input  logic [R*N*LANE_W-1:0]     req_data_flat,
    output logic [R-1:0]              req_ready,
    output logic                      sm_valid_in,
    output logic [N*LANE_W-1:0]       sm_in_x_flat,
    output logic                      sm_en,
    input  logic                      sm_valid_out,
    input  logic [N*LANE_W-1:0]       sm_prob_flat,
    output logic                      rsp_valid,
    output logic [clog2(R)-1:0]       rsp_id,
    output logic [N*LANE_W-1:0]       rsp_data_flat,
    input  logic                      rsp_ready,
    output logic [clog2(DEPTH+1)-1:0] inflight,
    output logic                      err_orphan
);

    localparam int RID_W = clog2(R);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int VEC_W = N * LANE_W;

    typedef logic [RID_W-1:0] rid_t;

    function automatic rid_t rr_next(input rid_t id);
        return (int'(id) == R - 1) ? '0 : rid_t'(int'(id) + 1);
    endfunction

    rid_t             rr_ptr;
    rid_t             gnt_id;
    rid_t             idx;
    logic [R-1:0]     grant;
    logic             found;
    logic             issue;
    logic             retire;
    logic             can_issue;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] inflight_eff;
    logic [VEC_W-1:0] sel_vec;
    logic             vld_p0;
    logic [VEC_W-1:0] x_p0;

    assign rsp_valid     = sm_valid_out & ~fifo_empty;
    assign rsp_data_flat = sm_prob_flat;
    assign retire        = rsp_valid & rsp_ready;
    assign sm_en         = ~(sm_valid_out & ~rsp_ready);

    // Retire is folded into the occupancy test so a full pipe can still accept one.
    assign inflight_eff = inflight - CNT_W'(retire);
    assign can_issue    = rst & sm_en & (~fifo_full | retire) &
                          (inflight_eff < CNT_W'(DEPTH));

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        if (can_issue) begin
            for (int i = 0; i < R; i++) begin
                idx = rid_t'((int'(rr_ptr) + i) % R);
                if (!found && req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    gnt_id     = idx;
                    found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_vec = '0;
        for (int r = 0; r < R; r++) begin
            if (grant[r]) begin
                sel_vec = req_data_flat[r*VEC_W +: VEC_W];
            end
        end
    end

    assign req_ready    = grant;
    assign issue        = found;
    assign sm_valid_in  = vld_p0;
    assign sm_in_x_flat = x_p0;

    // p0: pipeline input register; frozen while the softmax stage is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0     <= 1'b0;
            x_p0       <= '0;
            rr_ptr     <= '0;
            inflight   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (sm_en) begin
                vld_p0 <= issue;
                if (issue) begin
                    x_p0 <= sel_vec;
                end
            end
            if (issue) begin
                rr_ptr <= rr_next(gnt_id);
            end
            case ({issue, retire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            if (sm_valid_out && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    tag_fifo #(
        .DEPTH (DEPTH),
        .W     (RID_W)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (retire),
        .din   (gnt_id),
        .head  (rsp_id),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_softmax_arbiter.sv
// Bench for softmax_arbiter with a stand-in 7-stage softmax pipeline and a
// scoreboard that pairs each issued vector with its tagged response.
module tb_softmax_arbiter;
    import softmax_pkg::*;

    localparam int N     = 8;
    localparam int R     = 4;
    localparam int DEPTH = 8;
    localparam int L     = 7;
    localparam int VW    = N * LANE_W;
    localparam logic [VW-1:0] MASK = {N{16'hA5A5}};

    logic              clk;
    logic              rst;
    logic [R-1:0]      req_valid;
    logic [R*VW-1:0]   req_data_flat;
    logic [R-1:0]      req_ready;
    logic              sm_valid_in;
    logic [VW-1:0]     sm_in_x_flat;
    logic              sm_en;
    logic              sm_valid_out;
    logic [VW-1:0]     sm_prob_flat;
    logic              rsp_valid;
    req_id_t           rsp_id;
    logic [VW-1:0]     rsp_data_flat;
    logic              rsp_ready;
    logic [3:0]        inflight;
    logic              err_orphan;
    logic              force_vo;

    softmax_arbiter #(.N(N), .R(R), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data_flat (req_data_flat),
        .req_ready     (req_ready),
        .sm_valid_in   (sm_valid_in),
        .sm_in_x_flat  (sm_in_x_flat),
        .sm_en         (sm_en),
        .sm_valid_out  (sm_valid_out),
        .sm_prob_flat  (sm_prob_flat),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_data_flat (rsp_data_flat),
        .rsp_ready     (rsp_ready),
        .inflight      (inflight),
        .err_orphan    (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in softmax: L-stage stallable pipeline, output = input ^ MASK.
    logic          vld_s [L];
    logic [VW-1:0] dat_s [L];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                vld_s[i] <= 1'b0;
                dat_s[i] <= '0;
            end
        end else if (sm_en) begin
            vld_s[0] <= sm_valid_in;
            dat_s[0] <= sm_in_x_flat;
            for (int i = 1; i < L; i++) begin
                vld_s[i] <= vld_s[i-1];
                dat_s[i] <= dat_s[i-1];
            end
        end
    end

    assign sm_valid_out = vld_s[L-1] | force_vo;
    assign sm_prob_flat = dat_s[L-1] ^ MASK;

    typedef struct packed {
        req_id_t       id;
        logic [VW-1:0] data;
    } exp_t;

    exp_t          sb [$];
    int            glog [$];
    exp_t          mon_push;
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    int            rsp_count = 0;
    int            cyc = 0;
    int            grant_cyc = 0;
    int            rsp_cyc = 0;
    req_id_t       last_id;
    logic [VW-1:0] last_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic chki(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Monitor: push on transfer, pop and compare on retire.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
        end else begin
            chki("req_ready_onehot", int'($onehot0(req_ready)), 1);
            for (int r = 0; r < R; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    mon_push.id   = req_id_t'(r);
                    mon_push.data = req_data_flat[r*VW +: VW] ^ MASK;
                    sb.push_back(mon_push);
                    glog.push_back(r);
                    grant_cyc = cyc;
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                rsp_cyc   = cyc;
                last_id   = rsp_id;
                last_data = rsp_data_flat;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got id %0d expected none", rsp_id);
                end else begin
                    mon_e = sb.pop_front();
                    chki("rsp_id", int'(rsp_id), int'(mon_e.id));
                    chk("rsp_data", rsp_data_flat, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (inflight != 0 && n < 300) begin
            step();
            n++;
        end
        @(negedge clk);
        chki("drain_inflight", int'(inflight), 0);
        chki("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic set_vecs();
        for (int r = 0; r < R; r++) begin
            for (int l = 0; l < N; l++) begin
                req_data_flat[(r*N + l)*LANE_W +: LANE_W] = 16'(16'h0100 * (r + 1) + l);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int g0;
        rst           = 1'b0;
        req_valid     = '0;
        req_data_flat = '0;
        rsp_ready     = 1'b1;
        force_vo      = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chki("rst_req_ready", int'(req_ready), 0);
        chki("rst_sm_valid_in", int'(sm_valid_in), 0);
        chk("rst_sm_in_x", sm_in_x_flat, '0);
        chki("rst_inflight", int'(inflight), 0);
        chki("rst_err_orphan", int'(err_orphan), 0);
        chki("rst_rsp_valid", int'(rsp_valid), 0);
        step();
        rst = 1'b1;

        // Single requester 2, x=1.0 in lane 0, y=0 in lane 1.
        req_data_flat[2*VW +: LANE_W] = 16'h0400;
        req_valid = 4'b0100;
        @(negedge clk);
        chki("t1_grant", int'(req_ready), 4);
        step();
        req_valid = '0;
        drain();
        chki("t1_rsp_count", rsp_count, 1);
        chki("t1_rsp_id", int'(last_id), 2);
        chk("t1_rsp_data", last_data, {{7{16'hA5A5}}, 16'hA1A5});
        chki("t1_latency", rsp_cyc - grant_cyc, 8);

        // All requesters valid for 12 cycles: strict rotation.
        do_reset();
        set_vecs();
        glog.delete();
        c0 = rsp_count;
        req_valid = 4'hF;
        repeat (12) step();
        req_valid = '0;
        chki("t2_grants", glog.size(), 12);
        for (int i = 0; i < 12 && i < glog.size(); i++) begin
            chki($sformatf("t2_grant%0d", i), glog[i], i % 4);
        end
        drain();
        chki("t2_rsps", rsp_count - c0, 12);

        // Consumer back-pressure for 5 cycles mid-stream.
        do_reset();
        c0 = rsp_count;
        g0 = glog.size();
        req_valid = 4'hF;
        repeat (10) step();
        @(negedge clk);
        chki("t3_en_before", int'(sm_en), 1);
        chki("t3_valid_out", int'(sm_valid_out), 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chki($sformatf("t3_en_stall%0d", i), int'(sm_en), 0);
            chki($sformatf("t3_no_grant%0d", i), int'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chki("t3_en_after", int'(sm_en), 1);
        repeat (4) step();
        req_valid = '0;
        drain();
        chki("t3_no_loss", rsp_count - c0, glog.size() - g0);

        // Fill to DEPTH with the consumer stalled, then one retire.
        do_reset();
        rsp_ready = 1'b0;
        g0 = glog.size();
        req_valid = 4'hF;
        repeat (12) step();
        @(negedge clk);
        chki("t4_issued", glog.size() - g0, 8);
        chki("t4_blocked", int'(req_ready), 0);
        chki("t4_inflight_full", int'(inflight), 8);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chki("t4_regrant", int'(req_ready), 1);
        chki("t4_rsp_valid", int'(rsp_valid), 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chki("t4_one_only", int'(req_ready), 0);
        chki("t4_inflight_hold", int'(inflight), 8);
        chki("t4_issued_total", glog.size() - g0, 9);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        drain();

        // Orphan result, then reset with a vector in flight.
        do_reset();
        force_vo = 1'b1;
        @(negedge clk);
        chki("t5_orphan_rsp_valid", int'(rsp_valid), 0);
        step();
        force_vo = 1'b0;
        @(negedge clk);
        chki("t5_orphan_set", int'(err_orphan), 1);
        repeat (3) step();
        @(negedge clk);
        chki("t5_orphan_sticky", int'(err_orphan), 1);
        chki("t5_rsp_valid_idle", int'(rsp_valid), 0);
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (2) step();
        c0 = rsp_count;
        rst = 1'b0;
        step();
        @(negedge clk);
        chki("t5_rst_req_ready", int'(req_ready), 0);
        chki("t5_rst_sm_valid_in", int'(sm_valid_in), 0);
        chk("t5_rst_sm_in_x", sm_in_x_flat, '0);
        chki("t5_rst_inflight", int'(inflight), 0);
        chki("t5_rst_err_orphan", int'(err_orphan), 0);
        chki("t5_rst_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chki("t5_no_stale", rsp_count - c0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
